// File: rtl/chip8_loader_pkg.sv
// Shared constants and the loader FSM state type.
package chip8_loader_pkg;

  localparam logic [7:0] CHIP8_SYNC_BYTE = 8'hC8;
  localparam int unsigned CHIP8_BASE_ADDR = 512;

  localparam logic [1:0] CHIP8_ERR_NONE    = 2'd0;
  localparam logic [1:0] CHIP8_ERR_LEN     = 2'd1;
  localparam logic [1:0] CHIP8_ERR_CSUM    = 2'd2;
  localparam logic [1:0] CHIP8_ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_CSUM
  } state_t;

endpackage

// File: rtl/chip8_loader_gap_timer.sv
// Inter-byte gap counter: clears on every byte, counts while a frame is open,
// and flags the cycle in which the gap reaches LIMIT without a byte arriving.
module chip8_gap_timer #(
  parameter int unsigned LIMIT = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != TOP) begin
      count <= count + W'(1);
    end
  end

  // A byte in the expiry cycle clears the counter and wins over the timeout.
  assign expire = en && !clr && (count == LAST);

endmodule

// File: rtl/chip8_loader.sv
// Receives a framed CHIP-8 image over the UART byte stream, writes it into program
// memory from BASE_ADDR upward, and holds the interpreter until a frame checks out.
module chip8_loader
  import chip8_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BASE_ADDR      = CHIP8_BASE_ADDR,
  parameter logic [7:0]  SYNC_BYTE      = CHIP8_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_i,
  input  logic                  rx_i_v,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_d,
  output logic                  cpu_hold,
  output logic                  cpu_restart,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code
);

  localparam int LW = 2 * DATA_WIDTH;
  localparam int unsigned MAX_LEN_I = (1 << ADDR_WIDTH) - BASE_ADDR;
  localparam logic [LW:0] MAX_LEN = MAX_LEN_I[LW:0];
  localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

  state_t                state;
  logic [DATA_WIDTH-1:0] len_h;
  logic [LW-1:0]         len;
  logic [LW-1:0]         idx;
  logic [DATA_WIDTH-1:0] sum;

  logic [LW-1:0]         len_new;
  logic                  len_bad;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  frame_open;
  logic                  gap_expire;

  assign len_new    = {len_h, rx_i};
  assign len_bad    = (len_new == '0) || ({1'b0, len_new} > MAX_LEN);
  assign sum_next   = sum + rx_i;
  assign frame_open = (state != ST_IDLE);

  chip8_gap_timer #(.LIMIT(TIMEOUT_CYCLES)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_i_v),
    .en     (frame_open),
    .expire (gap_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_h       <= '0;
      len         <= '0;
      idx         <= '0;
      sum         <= '0;
      mem_we      <= 1'b0;
      mem_waddr   <= BASE;
      mem_d       <= '0;
      cpu_hold    <= 1'b0;
      cpu_restart <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      err_code    <= CHIP8_ERR_NONE;
    end else begin
      mem_we      <= 1'b0;
      cpu_restart <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      if (rx_i_v) begin
        unique case (state)
          ST_IDLE: begin
            if (rx_i == SYNC_BYTE) begin
              state    <= ST_LEN_H;
              cpu_hold <= 1'b1;
              err_code <= CHIP8_ERR_NONE;
              sum      <= '0;
              idx      <= '0;
            end
          end
          ST_LEN_H: begin
            len_h <= rx_i;
            state <= ST_LEN_L;
          end
          ST_LEN_L: begin
            if (len_bad) begin
              load_err <= 1'b1;
              err_code <= CHIP8_ERR_LEN;
              state    <= ST_IDLE;
            end else begin
              len   <= len_new;
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_waddr <= BASE + idx[ADDR_WIDTH-1:0];
            mem_d     <= rx_i;
            sum       <= sum_next;
            idx       <= idx + LW'(1);
            if (idx == len - LW'(1)) state <= ST_CSUM;
          end
          ST_CSUM: begin
            // Hold stays up on a bad image: memory may already be partly overwritten.
            if (sum_next == '0) begin
              load_done   <= 1'b1;
              cpu_restart <= 1'b1;
              cpu_hold    <= 1'b0;
            end else begin
              load_err <= 1'b1;
              err_code <= CHIP8_ERR_CSUM;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (gap_expire) begin
        load_err <= 1'b1;
        err_code <= CHIP8_ERR_TIMEOUT;
        state    <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_chip8_loader.sv
// Randomized and directed stimulus for chip8_loader, checked every cycle against a
// frame-level behavioural model, plus literal expectations for the reference frames.
module tb_chip8_loader;

  localparam int BASE = 512;
  localparam int TO   = 16;
  localparam int MAXL = 3584;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx = 8'h00;
  logic        rx_v = 1'b0;
  logic        mem_we, cpu_hold, cpu_restart, load_done, load_err;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_d;
  logic [1:0]  err_code;

  chip8_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_i(rx), .rx_i_v(rx_v),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_d(mem_d),
    .cpu_hold(cpu_hold), .cpu_restart(cpu_restart),
    .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: frame bytes collected in a queue ----------------
  bit          model_live = 0;
  bit          in_frame = 0;
  logic [7:0]  fb[$];
  int          gap = 0, flen = 0, n, s;
  logic        e_we = 0, e_hold = 0, e_rs = 0, e_done = 0, e_err = 0;
  logic [1:0]  e_code = 0;
  logic [11:0] e_waddr = 12'(BASE);
  logic [7:0]  e_d = 0;

  task automatic model_fail(input logic [1:0] c);
    in_frame = 0;
    e_err    = 1;
    e_code   = c;
  endtask

  always @(posedge clk) begin
    e_we = 0; e_rs = 0; e_done = 0; e_err = 0;
    if (rst) begin
      model_live = 1; in_frame = 0; fb.delete(); gap = 0;
      e_hold = 0; e_code = 0; e_waddr = 12'(BASE); e_d = 0;
    end else if (rx_v) begin
      gap = 0;
      if (!in_frame) begin
        if (rx == 8'hC8) begin
          in_frame = 1; fb.delete(); e_hold = 1; e_code = 0;
        end
      end else begin
        fb.push_back(rx);
        n = fb.size();
        if (n == 2) begin
          flen = int'(fb[0]) * 256 + int'(fb[1]);
          if (flen == 0 || flen > MAXL) model_fail(2'd1);
        end else if (n > 2 && n <= flen + 2) begin
          e_we = 1; e_waddr = 12'(BASE + n - 3); e_d = rx;
        end else if (n == flen + 3) begin
          s = 0;
          for (int i = 2; i < n; i++) s += int'(fb[i]);
          if (s % 256 == 0) begin
            in_frame = 0; e_done = 1; e_rs = 1; e_hold = 0;
          end else model_fail(2'd2);
        end
      end
    end else if (in_frame) begin
      gap++;
      if (gap >= TO) model_fail(2'd3);
    end
  end

  // ---------------- per-cycle compare and activity log ----------------
  logic [19:0] wlog[$];
  int cyc = 0, done_cnt = 0, err_cnt = 0, rs_cnt = 0, last_we_cyc = 0, last_err_cyc = 0;

  always @(negedge clk) begin
    if (model_live) begin
      check("mem_we", mem_we, e_we);
      check("cpu_hold", cpu_hold, e_hold);
      check("cpu_restart", cpu_restart, e_rs);
      check("load_done", load_done, e_done);
      check("load_err", load_err, e_err);
      check("err_code", err_code, e_code);
      if (e_we) begin
        check("mem_waddr", mem_waddr, e_waddr);
        check("mem_d", mem_d, e_d);
      end
      cyc++;
      if (mem_we === 1'b1) begin wlog.push_back({mem_waddr, mem_d}); last_we_cyc = cyc; end
      if (load_done === 1'b1) done_cnt++;
      if (cpu_restart === 1'b1) rs_cnt++;
      if (load_err === 1'b1) begin err_cnt++; last_err_cyc = cyc; end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] txq[$];

  task automatic slot(input logic v, input logic [7:0] b);
    @(posedge clk); #1;
    rx_v = v; rx = b;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) slot(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rx_v = 0; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic build(input int len, input bit good);
    int sm;
    logic [7:0] b;
    txq.delete();
    txq.push_back(8'hC8); txq.push_back(8'(len >> 8)); txq.push_back(8'(len));
    if (len >= 1 && len <= MAXL) begin
      sm = 0;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom); txq.push_back(b); sm += int'(b);
      end
      if (good) txq.push_back(8'(0 - sm));
      else      txq.push_back(8'(0 - sm + 1 + int'($urandom_range(0, 254))));
    end
  endtask

  task automatic send_txq(input bit gaps);
    int r;
    foreach (txq[i]) begin
      if (gaps && i > 0) begin
        r = $urandom_range(0, 15);
        if (r == 11) idle(1);
        else if (r == 12) idle(3);
        else if (r == 13) idle(TO - 1);
        else if (r == 14) idle(TO);
      end
      slot(1'b1, txq[i]);
    end
  endtask

  int d0, e0, r0, nn, kind;
  logic [7:0] nb;
  logic [19:0] w;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_we", mem_we, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_restart", cpu_restart, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_code", err_code, 0);
    check("rst_waddr", mem_waddr, 12'h200);
    check("rst_d", mem_d, 0);

    // good frame
    wlog.delete(); d0 = done_cnt; r0 = rs_cnt;
    txq = '{8'hC8, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    send_txq(0); idle(3);
    check("t1_nw", wlog.size(), 3);
    w = wlog[0]; check("t1_w0", w, 20'h20011);
    w = wlog[1]; check("t1_w1", w, 20'h20122);
    w = wlog[2]; check("t1_w2", w, 20'h20233);
    check("t1_done", done_cnt - d0, 1);
    check("t1_restart", rs_cnt - r0, 1);
    check("t1_hold", cpu_hold, 0);
    check("t1_code", err_code, 0);

    // bad checksum (AA+55+02 = 0x101), then a good frame releases hold
    wlog.delete(); e0 = err_cnt;
    txq = '{8'hC8, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h02};
    send_txq(0); idle(2);
    check("t2_nw", wlog.size(), 2);
    check("t2_err", err_cnt - e0, 1);
    check("t2_code", err_code, 2);
    check("t2_hold", cpu_hold, 1);
    txq = '{8'hC8, 8'h00, 8'h01, 8'h05, 8'hFB};
    send_txq(0); idle(2);
    check("t2_release", cpu_hold, 0);

    // length boundaries
    wlog.delete(); e0 = err_cnt; d0 = done_cnt;
    txq = '{8'hC8, 8'h00, 8'h00}; send_txq(0); idle(2);
    check("t3_len0_code", err_code, 1);
    txq = '{8'hC8, 8'h0E, 8'h01}; send_txq(0); idle(2);
    check("t3_len3585_code", err_code, 1);
    check("t3_err", err_cnt - e0, 2);
    check("t3_nowrite", wlog.size(), 0);
    check("t3_hold", cpu_hold, 1);
    build(MAXL, 1); send_txq(0); idle(2);
    check("t3_full_nw", wlog.size(), MAXL);
    w = wlog[wlog.size() - 1]; check("t3_last_addr", w[19:8], 12'hFFF);
    check("t3_full_done", done_cnt - d0, 1);

    // timeout: byte at gap 16 accepted, silence of 16 expires
    wlog.delete(); e0 = err_cnt;
    txq = '{8'hC8, 8'h00, 8'h04, 8'h11}; send_txq(0);
    idle(TO - 1); slot(1'b1, 8'h22); idle(TO + 3);
    check("t4_nw", wlog.size(), 2);
    w = wlog[1]; check("t4_w1", w, 20'h20122);
    check("t4_err", err_cnt - e0, 1);
    check("t4_code", err_code, 3);
    check("t4_gap", last_err_cyc - last_we_cyc, TO);
    check("t4_hold", cpu_hold, 1);

    // noise and back-to-back frames
    wlog.delete(); d0 = done_cnt;
    txq = '{8'h00, 8'hFF, 8'hC8, 8'h00, 8'h01, 8'hC8, 8'h38,
            8'hC8, 8'h00, 8'h01, 8'h05, 8'hFB};
    send_txq(0); idle(2);
    check("t5_nw", wlog.size(), 2);
    w = wlog[0]; check("t5_w0", w, 20'h200C8);
    w = wlog[1]; check("t5_w1", w, 20'h20005);
    check("t5_done", done_cnt - d0, 2);

    // reset mid-DATA
    e0 = err_cnt; d0 = done_cnt;
    txq = '{8'hC8, 8'h00, 8'h05, 8'h01, 8'h02}; send_txq(0);
    do_reset();
    check("t6_hold", cpu_hold, 0);
    check("t6_waddr", mem_waddr, 12'h200);
    check("t6_d", mem_d, 0);
    check("t6_code", err_code, 0);
    idle(3);
    check("t6_noerr", err_cnt - e0, 0);
    txq = '{8'hC8, 8'h00, 8'h01, 8'h05, 8'hFB}; send_txq(0); idle(2);
    check("t6_done", done_cnt - d0, 1);

    // randomized frames with noise, odd lengths, bad sums, gaps and resets
    for (int f = 0; f < 80; f++) begin
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        nb = 8'($urandom);
        if (nb == 8'hC8) nb = 8'h00;
        slot(1'b1, nb);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0)      build(0, 1);
      else if (kind == 1) build(MAXL + 1 + $urandom_range(0, 3), 1);
      else                build($urandom_range(1, 12), ($urandom_range(0, 3) != 0));
      send_txq(1);
      if ($urandom_range(0, 29) == 0) do_reset();
      idle($urandom_range(0, 2));
    end
    idle(TO + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
